// File: rtl/clock_alarm_pkg.sv
// Shared definitions for the clock-alarm button path: button indices,
// per-channel debounce FSM states and a width helper.
package clock_alarm_pkg;

  localparam int unsigned NUM_BTN      = 4;
  localparam int unsigned BTN_SET_MODE = 0;
  localparam int unsigned BTN_INC_HOUR = 1;
  localparam int unsigned BTN_INC_MIN  = 2;
  localparam int unsigned BTN_CONFIRM  = 3;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_HELD,
    ST_RELEASE_CHK
  } btn_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with stable-cycle
// counter, and an optional auto-repeat timer that runs while the button is held.
module button_channel
  import clock_alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned      CNT_W    = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                                      REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LIM  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic             RAW_IDLE = ACTIVE_LOW_IN;

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rpt_q, rpt_d;
  logic             first_q, first_d;
  logic             level_q, level_d, pulse_q, pulse_d;
  logic             pressed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    pressed = sync2_q ^ ACTIVE_LOW_IN;
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    first_d = first_q;
    level_d = level_q;
    pulse_d = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        rpt_d   = '0;
        first_d = 1'b1;
        if (pressed) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PRESS_CHK: begin
        if (!pressed) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LIM) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
          rpt_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_RELEASE_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RELEASE_CHK: begin
        if (pressed) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LIM) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
          rpt_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Repeat timer keeps running through a release bounce; the release edge itself never repeats.
    if (REPEAT_EN && (state_q == ST_HELD || state_q == ST_RELEASE_CHK) &&
        state_d != ST_RELEASED) begin
      if (rpt_q == (first_q ? DLY_LIM : PER_LIM)) begin
        pulse_d = 1'b1;
        rpt_d   = '0;
        first_d = 1'b0;
      end else begin
        rpt_d = sat_inc(rpt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      rpt_q   <= '0;
      first_q <= 1'b1;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Four independent button channels feeding the PIO: debounced levels plus
// single-cycle press / auto-repeat pulses.
module button_conditioner
  import clock_alarm_pkg::*;
#(
  parameter int unsigned        DEBOUNCE_CYCLES = 500000,
  parameter int unsigned        REPEAT_DELAY    = 25000000,
  parameter int unsigned        REPEAT_PERIOD   = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0110,
  parameter bit                 ACTIVE_LOW_IN   = 1'b1
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i]),
      .ACTIVE_LOW_IN  (ACTIVE_LOW_IN)
    ) u_ch (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length behavioural model checked every
// cycle, plus directed scenarios with hand-computed event cycles.
module tb_button_conditioner;
  import clock_alarm_pkg::*;

  localparam int D    = 4;
  localparam int DLY  = 20;
  localparam int PER  = 8;
  localparam logic [3:0] MASK = 4'b0110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .REPEAT_MASK    (MASK),
    .ACTIVE_LOW_IN  (1'b1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_pulse    (btn_pulse)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Model: sync = raw two edges ago; level flips after D+1 consecutive
  // disagreeing samples; repeats counted in edges since the last pulse.
  logic [3:0] m_h1, m_h2, m_level, m_pulse;
  int   m_run[4], m_since[4], m_target[4];
  logic m_s;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_h1 = 4'hF; m_h2 = 4'hF; m_level = '0; m_pulse = '0;
      for (int c = 0; c < 4; c++) begin
        m_run[c] = 0; m_since[c] = 0; m_target[c] = DLY;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        m_s = ~m_h2[c];
        m_pulse[c] = 1'b0;
        m_run[c] = (m_s != m_level[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == D + 1) begin
          m_level[c] = m_s;
          m_run[c] = 0;
          if (m_s) begin
            m_pulse[c] = 1'b1; m_since[c] = 0; m_target[c] = DLY;
          end
        end else if (m_level[c] && MASK[c]) begin
          m_since[c] = m_since[c] + 1;
          if (m_since[c] == m_target[c]) begin
            m_pulse[c] = 1'b1; m_since[c] = 0; m_target[c] = PER;
          end
        end
      end
      m_h2 = m_h1;
      m_h1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse) begin
        errors++;
        $display("FAIL model edge=%0d level=%b exp=%b pulse=%b exp=%b",
                 cyc - 1, btn_level, m_level, btn_pulse, m_pulse);
      end
    end
  end

  // Event recorder for one watched channel (absolute edge indices).
  int   watch_ch = 0;
  int   pq[$];
  int   exp_q[$];
  int   t0, rise_at, fall_at, n_fall;
  bit   prev_lvl = 1'b0, any_out;

  always @(negedge clk) begin
    if (btn_pulse[watch_ch]) pq.push_back(cyc - 1);
    if (btn_level[watch_ch] && !prev_lvl) rise_at = cyc - 1;
    if (!btn_level[watch_ch] && prev_lvl) begin
      fall_at = cyc - 1;
      n_fall++;
    end
    if (btn_level[watch_ch] || btn_pulse[watch_ch]) any_out = 1'b1;
    prev_lvl = btn_level[watch_ch];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic begin_scenario(input int ch);
    watch_ch = ch;
    pq.delete();
    rise_at = -1; fall_at = -1; n_fall = 0; any_out = 1'b0;
    t0 = cyc;
  endtask

  task automatic check_pulses(input string name);
    check({name, "_count"}, pq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_%0d", name, i), (i < pq.size()) ? pq[i] - t0 : -1, exp_q[i]);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_raw = 4'hF;
    ticks(3);
    check("reset_level", int'(btn_level), 0);
    check("reset_pulse", int'(btn_pulse), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    ticks(2);

    // Clean press and release on confirm (no repeat).
    begin_scenario(BTN_CONFIRM);
    btn_raw[BTN_CONFIRM] = 1'b0;
    ticks(40);
    btn_raw[BTN_CONFIRM] = 1'b1;
    ticks(20);
    check("confirm_rise", rise_at - t0, 6);
    check("confirm_fall", fall_at - t0, 46);
    exp_q = {6};
    check_pulses("confirm_pulse");

    // Bounce: 3-cycle low phases never reach the output.
    begin_scenario(BTN_SET_MODE);
    for (int k = 0; k < 5; k++) begin
      btn_raw[BTN_SET_MODE] = 1'b0;
      ticks(3);
      btn_raw[BTN_SET_MODE] = 1'b1;
      ticks(3);
    end
    ticks(20);
    check("bounce_any_output", int'(any_out), 0);

    // Auto-repeat on inc_hour.
    begin_scenario(BTN_INC_HOUR);
    btn_raw[BTN_INC_HOUR] = 1'b0;
    ticks(50);
    btn_raw[BTN_INC_HOUR] = 1'b1;
    ticks(20);
    check("hour_rise", rise_at - t0, 6);
    check("hour_fall", fall_at - t0, 56);
    exp_q = {6, 26, 34, 42, 50};
    check_pulses("hour_pulse");

    // Release glitch on inc_min: level holds, repeat schedule unchanged.
    begin_scenario(BTN_INC_MIN);
    btn_raw[BTN_INC_MIN] = 1'b0;
    ticks(10);
    btn_raw[BTN_INC_MIN] = 1'b1;
    ticks(2);
    btn_raw[BTN_INC_MIN] = 1'b0;
    ticks(26);
    btn_raw[BTN_INC_MIN] = 1'b1;
    ticks(20);
    check("min_rise", rise_at - t0, 6);
    check("min_fall_count", n_fall, 1);
    check("min_fall", fall_at - t0, 44);
    exp_q = {6, 26, 34, 42};
    check_pulses("min_pulse");

    // Simultaneous press on set_mode and confirm.
    begin_scenario(BTN_SET_MODE);
    btn_raw[BTN_SET_MODE] = 1'b0;
    btn_raw[BTN_CONFIRM]  = 1'b0;
    ticks(6);
    check("simul_level_c5", int'(btn_level), 0);
    ticks(1);
    check("simul_level_c6", int'(btn_level), 9);
    check("simul_pulse_c6", int'(btn_pulse), 9);
    ticks(1);
    check("simul_pulse_c7", int'(btn_pulse), 0);
    ticks(12);
    btn_raw = 4'hF;
    ticks(20);
    check("simul_released", int'(btn_level), 0);

    // Reset while inc_hour is held.
    begin_scenario(BTN_INC_HOUR);
    btn_raw[BTN_INC_HOUR] = 1'b0;
    ticks(10);
    check("rst_pre_level", int'(btn_level[BTN_INC_HOUR]), 1);
    rst_n = 1'b0;
    ticks(1);
    check("rst_level", int'(btn_level), 0);
    check("rst_pulse", int'(btn_pulse), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(6);
    check("rst_relevel_c18", int'(btn_level[BTN_INC_HOUR]), 0);
    ticks(1);
    check("rst_repulse_c19", int'(btn_pulse[BTN_INC_HOUR]), 1);
    check("rst_relevel_c19", int'(btn_level[BTN_INC_HOUR]), 1);
    ticks(4);
    btn_raw = 4'hF;
    ticks(20);
    check("rst_final_level", int'(btn_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
